// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the bit serializer.
// Optional feature macro: BIT_SERIALIZER_PARITY_EN (appends one even-parity bit per frame).
package bit_serializer_pkg;

`ifdef BIT_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    localparam int unsigned PAR_BITS = 1;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;

    localparam int unsigned PAR_BITS = 0;
`endif

endpackage

// File: rtl/bit_serializer_tick.sv
// Bit hold counter: strobes tick_c in the last of DIV cycles of each serial bit.
module bit_tick_gen #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick_c
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick_c = (cnt == CW'(DIV - 1));

    // Hold counter: cleared on word accept, wraps DIV-1 -> 0 while a frame is in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick_c ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter, MSB first, each bit held DIV cycles.
// Optional feature macro: BIT_SERIALIZER_PARITY_EN (even-parity bit after bit 0).
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy
);

    localparam int unsigned BW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [BW-1:0]    bit_cnt;
    logic             tick_c;
    logic             last_cycle_c;
    logic             accept_c;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic             par_bit;
`endif

    // Final cycle of the final bit of the frame (data bit 0, or the parity bit)
`ifdef BIT_SERIALIZER_PARITY_EN
    assign last_cycle_c = tick_c && (state == PAR);
`else
    assign last_cycle_c = tick_c && (state == SHIFT) && (bit_cnt == '0);
`endif

    // Ready when idle or about to finish; forced low during reset
    assign din_ready = rst && ((state == IDLE) || last_cycle_c);
    assign accept_c  = din_valid && din_ready;

    // The MSB of the shift register is the line; cleared register means idle line 0
    assign sout = sr[WIDTH-1];

    bit_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept_c),
        .en    (state != IDLE),
        .tick_c(tick_c)
    );

    // Frame FSM: load on accept, shift on each bit boundary, then parity or idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sr         <= '0;
            bit_cnt    <= '0;
            sout_valid <= 1'b0;
            busy       <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else if (accept_c) begin
            state      <= SHIFT;
            sr         <= din;
            bit_cnt    <= BW'(WIDTH - 1);
            sout_valid <= 1'b1;
            busy       <= 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_bit    <= ^din;
`endif
        end else begin
            case (state)
                SHIFT: begin
                    if (tick_c) begin
                        if (bit_cnt == '0) begin
`ifdef BIT_SERIALIZER_PARITY_EN
                            state <= PAR;
                            sr    <= {par_bit, (WIDTH-1)'(0)};
`else
                            state      <= IDLE;
                            sr         <= '0;
                            sout_valid <= 1'b0;
                            busy       <= 1'b0;
`endif
                        end else begin
                            sr      <= {sr[WIDTH-2:0], 1'b0};
                            bit_cnt <= bit_cnt - BW'(1);
                        end
                    end
                end
`ifdef BIT_SERIALIZER_PARITY_EN
                PAR: begin
                    if (tick_c) begin
                        state      <= IDLE;
                        sr         <= '0;
                        sout_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: directed frames, reset cases,
// detector end-to-end, and randomized traffic against a queue model.
module tb_bit_serializer;

`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int F = 8 + PB;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din1, din3;
    logic       dv1, dv3;
    logic       rdy1, so1, sv1, bz1;
    logic       rdy3, so3, sv3, bz3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .DIV(1)) dut1 (
        .clk(clk), .rst(rst), .din(din1), .din_valid(dv1),
        .din_ready(rdy1), .sout(so1), .sout_valid(sv1), .busy(bz1)
    );

    bit_serializer #(.WIDTH(8), .DIV(3)) dut3 (
        .clk(clk), .rst(rst), .din(din3), .din_valid(dv3),
        .din_ready(rdy3), .sout(so3), .sout_valid(sv3), .busy(bz3)
    );

    // Downstream 101 Moore detector: registered input, state, registered output
    logic       x_q;
    logic [1:0] det_st;
    logic       det_y;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q    <= 1'b0;
            det_st <= 2'd0;
            det_y  <= 1'b0;
        end else begin
            x_q   <= so1;
            det_y <= (det_st == 2'd3);
            case (det_st)
                2'd0:    det_st <= x_q ? 2'd1 : 2'd0;
                2'd1:    det_st <= x_q ? 2'd1 : 2'd2;
                2'd2:    det_st <= x_q ? 2'd3 : 2'd0;
                default: det_st <= x_q ? 2'd1 : 2'd2;
            endcase
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic frame_bit(input logic [7:0] w, input int i);
        return (i < 8) ? w[7-i] : ^w;
    endfunction

    task automatic test_reset();
        rst = 1'b0; dv1 = 1'b1; dv3 = 1'b1; din1 = 8'hFF; din3 = 8'hFF;
        repeat (3) @(negedge clk);
        checks++;
        if ({so1, sv1, bz1, rdy1} !== 4'b0000) begin
            errors++; $display("FAIL reset_dut1: got %b want 0000", {so1, sv1, bz1, rdy1});
        end
        checks++;
        if ({so3, sv3, bz3, rdy3} !== 4'b0000) begin
            errors++; $display("FAIL reset_dut3: got %b want 0000", {so3, sv3, bz3, rdy3});
        end
        dv1 = 1'b0; dv3 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({so1, sv1, bz1, rdy1} !== 4'b0001) begin
            errors++; $display("FAIL idle_after_reset: got %b want 0001", {so1, sv1, bz1, rdy1});
        end
    endtask

    task automatic test_a5();
        logic [7:0] w = 8'hA5;
        @(negedge clk); din1 = w; dv1 = 1'b1;
        @(posedge clk); #1 dv1 = 1'b0;
        for (int i = 0; i < F; i++) begin
            @(negedge clk);
            checks++;
            if (so1 !== frame_bit(w, i) || sv1 !== 1'b1) begin
                errors++; $display("FAIL a5_bit%0d: got sout=%b valid=%b want sout=%b valid=1", i, so1, sv1, frame_bit(w, i));
            end
        end
        @(negedge clk);
        checks++;
        if (so1 !== 1'b0 || sv1 !== 1'b0) begin
            errors++; $display("FAIL a5_idle: got sout=%b valid=%b want 0 0", so1, sv1);
        end
    endtask

    task automatic test_div3();
        logic [7:0] w = 8'h81;
        @(negedge clk); din3 = w; dv3 = 1'b1;
        @(posedge clk); #1 dv3 = 1'b0;
        for (int c = 1; c <= F * 3; c++) begin
            @(negedge clk);
            checks++;
            if (so3 !== frame_bit(w, (c - 1) / 3) || sv3 !== 1'b1 || rdy3 !== (c == F * 3)) begin
                errors++;
                $display("FAIL div3_cyc%0d: got sout=%b valid=%b ready=%b want sout=%b valid=1 ready=%b",
                         c, so3, sv3, rdy3, frame_bit(w, (c - 1) / 3), (c == F * 3));
            end
        end
        @(negedge clk);
        checks++;
        if (so3 !== 1'b0 || sv3 !== 1'b0 || rdy3 !== 1'b1) begin
            errors++; $display("FAIL div3_idle: got sout=%b valid=%b ready=%b want 0 0 1", so3, sv3, rdy3);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] wa = 8'hA5;
        logic [7:0] wb = 8'h07;
        @(negedge clk); din1 = wa; dv1 = 1'b1;
        @(posedge clk); #1 din1 = wb;
        for (int c = 1; c <= 2 * F; c++) begin
            @(negedge clk);
            checks++;
            if (sv1 !== 1'b1 || so1 !== ((c <= F) ? frame_bit(wa, c - 1) : frame_bit(wb, c - 1 - F))) begin
                errors++; $display("FAIL b2b_cyc%0d: got sout=%b valid=%b", c, so1, sv1);
            end
            if (c == F) begin
                checks++;
                if (rdy1 !== 1'b1) begin
                    errors++; $display("FAIL b2b_ready: got %b want 1", rdy1);
                end
                @(posedge clk); #1 dv1 = 1'b0;
            end
        end
`ifdef BIT_SERIALIZER_PARITY_EN
        checks++;
        if (frame_bit(wa, 8) !== 1'b0 || frame_bit(wb, 8) !== 1'b1) begin
            errors++; $display("FAIL parity_model: got %b%b want 01", frame_bit(wa, 8), frame_bit(wb, 8));
        end
`endif
        @(negedge clk);
        checks++;
        if (so1 !== 1'b0 || sv1 !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: got sout=%b valid=%b want 0 0", so1, sv1);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] w = 8'h01;
        @(negedge clk); din1 = 8'hFF; dv1 = 1'b1;
        @(posedge clk); #1 dv1 = 1'b0;
        for (int c = 1; c <= 3; c++) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({so1, sv1, bz1, rdy1} !== 4'b0000) begin
            errors++; $display("FAIL midreset: got %b want 0000", {so1, sv1, bz1, rdy1});
        end
        @(posedge clk);
        @(negedge clk); rst = 1'b1; din1 = w; dv1 = 1'b1;
        @(posedge clk); #1 dv1 = 1'b0;
        for (int i = 0; i < F; i++) begin
            @(negedge clk);
            checks++;
            if (so1 !== frame_bit(w, i) || sv1 !== 1'b1) begin
                errors++; $display("FAIL after_reset_bit%0d: got sout=%b valid=%b want sout=%b valid=1", i, so1, sv1, frame_bit(w, i));
            end
        end
        @(negedge clk);
        checks++;
        if (sv1 !== 1'b0) begin
            errors++; $display("FAIL after_reset_idle: got valid=%b want 0", sv1);
        end
    endtask

    task automatic test_detector();
        int hits = 0;
        int first = -1;
        @(negedge clk); din1 = 8'hA0; dv1 = 1'b1;
        @(posedge clk); #1 dv1 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (det_y === 1'b1) begin
                hits++;
                if (first < 0) first = c;
            end
        end
        checks++;
        if (hits != 1 || first != 6) begin
            errors++; $display("FAIL detector: got hits=%0d at cycle %0d want hits=1 at cycle 6", hits, first);
        end
    endtask

    // Random traffic; model is a queue of expected per-cycle (valid,bit) entries
    task automatic test_random(input int which, input int n);
        int         q[$];
        int         cur;
        int         div;
        logic       exp_rdy, so, sv, rd, bz, v;
        logic [7:0] w;
        div = (which == 1) ? 1 : 3;
        for (int c = 0; c < n + 40; c++) begin
            @(negedge clk);
            cur     = (q.size() > 0) ? q.pop_front() : 0;
            exp_rdy = (q.size() == 0);
            if (which == 1) begin so = so1; sv = sv1; rd = rdy1; bz = bz1; v = dv1; w = din1; end
            else            begin so = so3; sv = sv3; rd = rdy3; bz = bz3; v = dv3; w = din3; end
            checks++;
            if ({sv, so, bz, rd} !== {cur[1], cur[0], cur[1], exp_rdy}) begin
                errors++;
                $display("FAIL rand%0d_cyc%0d: got valid=%b sout=%b busy=%b ready=%b want %b %b %b %b",
                         which, c, sv, so, bz, rd, cur[1], cur[0], cur[1], exp_rdy);
            end
            if (v && exp_rdy) begin
                for (int i = 0; i < F; i++)
                    for (int k = 0; k < div; k++) q.push_back(2 + int'(frame_bit(w, i)));
            end
            @(posedge clk); #1;
            v = (c < n) && ($urandom_range(0, 2) != 0);
            w = 8'($urandom);
            if (which == 1) begin dv1 = v; din1 = w; end
            else            begin dv3 = v; din3 = w; end
        end
    endtask

    initial begin
        rst = 1'b0; dv1 = 1'b0; dv3 = 1'b0; din1 = '0; din3 = '0;
        test_reset();
        test_a5();
        test_div3();
        test_back_to_back();
        test_reset_mid();
        test_detector();
        test_random(1, 300);
        test_random(3, 300);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, meaning parallel word width in bits (WIDTH >= 2).
REQ-002 SHALL provide parameter DIV, default 1, meaning clock cycles each serial bit is held (DIV >= 1).
REQ-003 SHALL provide port clk  input  1  clock; all state updates on posedge.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port din  input  WIDTH  parallel word to serialize.
REQ-006 SHALL provide port din_valid  input  1  din holds a valid word.
REQ-007 SHALL provide port din_ready  output  1  block accepts din this cycle.
REQ-008 SHALL provide port sout  output  1  serial bit stream, MSB first; feeds the downstream sequence detector x input.
REQ-009 SHALL provide port sout_valid  output  1  sout carries a data/parity bit this cycle.
REQ-010 SHALL provide port busy  output  1  word in flight (state != IDLE).

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, PAR (PAR exists only with PARITY_EN).
REQ-012 SHALL transfer a word on a posedge where din_valid && din_ready (handshake accept).
REQ-013 SHALL drive din_ready = 1 in IDLE, and in the final cycle of the final bit of the current word; 0 otherwise.
REQ-014 SHALL, on accept, load din into a shift register, set bit counter to WIDTH-1, clear hold counter, enter SHIFT.
REQ-015 SHALL register sout/sout_valid: MSB of an accepted word appears on sout with sout_valid=1 in the cycle after the accepting edge (latency 1).
REQ-016 SHALL hold each bit for exactly DIV cycles, then shift left by one; hold counter wraps DIV-1 -> 0.
REQ-017 SHALL, after bit 0 completes, go to PAR (PARITY_EN) or IDLE; if a new word is accepted in that cycle, go directly to SHIFT with no idle gap.
REQ-018 SHALL drive sout = 0 and sout_valid = 0 whenever no bit is in flight (idle line is 0).
REQ-019 SHALL ignore din_valid while din_ready = 0; din is not sampled.
REQ-020 SHALL keep din_ready = 0 while rst is low.

Reset
REQ-021 SHALL, on rst low, asynchronously set state IDLE, sout 0, sout_valid 0, busy 0, all counters and shift register 0.
REQ-022 SHALL abandon a partially sent word on reset mid-operation; no bits of it appear after rst releases.
REQ-023 SHALL accept a word on the first posedge after rst deasserts if din_valid = 1.

Configuration
REQ-024 SHALL, with macro BIT_SERIALIZER_PARITY_EN defined, append one even-parity bit (XOR of the WIDTH data bits) after bit 0, held DIV cycles with sout_valid = 1 in state PAR; din_ready rule of REQ-013 then applies to the final cycle of the parity bit.
REQ-025 SHALL, without the macro, omit state PAR and parity logic entirely; frame is WIDTH bits.

Structure
REQ-026 SHALL place the state enum type and the parity-bit-count constant (1 or 0 depending on the macro) in package bit_serializer_pkg.
REQ-027 SHALL implement the hold counter as sub-module bit_tick_gen (parameter DIV; outputs last-cycle-of-bit strobe; synchronous clear on accept).

Verification
REQ-028 SHALL cover: WIDTH=8, DIV=1, no parity, accept 0xA5 at edge 0 -> sout 1,0,1,0,0,1,0,1 on cycles 1-8 with sout_valid=1, then sout=0, sout_valid=0.
REQ-029 SHALL cover: DIV=3, accept 0x81 -> sout 1 for cycles 1-3, 0 for cycles 4-21, 1 for cycles 22-24; din_ready=1 only on cycle 24 before returning to IDLE.
REQ-030 SHALL cover: PARITY_EN, DIV=1, words 0xA5 then 0x07 -> 9th bit 0 then 1; frames back-to-back with no gap, sout_valid continuously 1 for 18 cycles.
REQ-031 SHALL cover: din_valid held high with changing din during SHIFT -> only words present on din_ready cycles are serialized.
REQ-032 SHALL cover: rst pulsed low after bit 3 of 0xFF -> sout=0, sout_valid=0 immediately; next accepted word 0x01 produces 0,0,0,0,0,0,0,1.
REQ-033 SHALL cover: end-to-end, DIV=1, stream 0xA0 into a 101 Moore detector -> detector y=1 exactly once, three cycles after the third bit (1) appears.
